// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM
// states, bit positions and the fixed-priority encoder.
package irq_pkg;

  typedef enum logic [1:0] {
    REG_PEND  = 2'd0,
    REG_MASK  = 2'd1,
    REG_CTRL  = 2'd2,
    REG_CAUSE = 2'd3
  } reg_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam int unsigned CTRL_GIE = 0;
  localparam int unsigned CAUSE_IS = 31;

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [3:0] prio_enc(input logic [15:0] v);
    logic [3:0] id;
    logic       found;
    id    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i] && !found) begin
        id    = 4'(i);
        found = 1'b1;
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One request source: multi-flop synchronizer followed by a rising-edge
// detector. rise is a single-cycle pulse per low-to-high transition.
module irq_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronized edge-triggered sources,
// PEND/MASK/CTRL/CAUSE registers, fixed-priority arbitration, non-nesting FSM.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  input  logic             int_ack,
  output logic             int_out,
  output logic [3:0]       cause_id
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend, pend_nx, mask, w1c, ack_clr, elig;
  logic [15:0]      elig_w;
  logic             gie, in_service, ack_fire, eoi;
  logic             we_pend, we_mask, we_ctrl;
  logic [3:0]       winner;
  state_e           state, state_nx;
  logic             unused_wdata;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (irq_in[g]),
      .rise (rise[g])
    );
  end

  assign we_pend      = reg_we && (reg_e'(reg_addr) == REG_PEND);
  assign we_mask      = reg_we && (reg_e'(reg_addr) == REG_MASK);
  assign we_ctrl      = reg_we && (reg_e'(reg_addr) == REG_CTRL);
  assign eoi          = reg_we && (reg_e'(reg_addr) == REG_CAUSE);
  assign unused_wdata = ^reg_wdata;

  assign elig   = pend & mask & {N_SRC{gie}};
  assign winner = prio_enc(elig_w);

  always_comb begin
    elig_w  = '0;
    ack_clr = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      elig_w[i]  = elig[i];
      ack_clr[i] = ack_fire && (cause_id == 4'(i));
    end
  end

  // A new rise is OR-ed in last so it survives a same-cycle W1C or ack clear.
  assign w1c     = we_pend ? reg_wdata[N_SRC-1:0] : '0;
  assign pend_nx = (pend & ~w1c & ~ack_clr) | rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      mask <= '0;
      gie  <= 1'b0;
    end else begin
      pend <= pend_nx;
      if (we_mask) mask <= reg_wdata[N_SRC-1:0];
      if (we_ctrl) gie  <= reg_wdata[CTRL_GIE];
    end
  end

  always_comb begin
    state_nx = state;
    ack_fire = 1'b0;
    case (state)
      IDLE: begin
        if (|elig) state_nx = REQ;
      end
      REQ: begin
        if (int_ack) begin
          ack_fire = 1'b1;
          state_nx = SERVICE;
        end else if (!elig_w[cause_id]) begin
          state_nx = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      int_out    <= 1'b0;
      in_service <= 1'b0;
      cause_id   <= '0;
    end else begin
      state      <= state_nx;
      int_out    <= (state_nx == REQ);
      in_service <= (state_nx == SERVICE);
      if (state == IDLE && |elig) cause_id <= winner;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_e'(reg_addr))
      REG_PEND:  reg_rdata[N_SRC-1:0] = pend;
      REG_MASK:  reg_rdata[N_SRC-1:0] = mask;
      REG_CTRL:  reg_rdata[CTRL_GIE]  = gie;
      REG_CAUSE: begin
        reg_rdata[CAUSE_IS] = in_service;
        reg_rdata[3:0]      = cause_id;
      end
      default:   reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with hand-computed expectations.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        int_ack;
  logic        int_out;
  logic [3:0]  cause_id;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] A_PEND = 2'd0, A_MASK = 2'd1, A_CTRL = 2'd2, A_CAUSE = 2'd3;

  irq_ctrl #(.N_SRC(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .int_ack   (int_ack),
    .int_out   (int_out),
    .cause_id  (cause_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; irq_in = '0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0; int_ack = 1'b0;
    ticks(2);
    rst = 1'b0;
    tick();

    // Reset state
    check_reg("rst_pend",  A_PEND,  32'h0);
    check_reg("rst_mask",  A_MASK,  32'h0);
    check_reg("rst_ctrl",  A_CTRL,  32'h0);
    check_reg("rst_cause", A_CAUSE, 32'h0);
    check("rst_int", {31'b0, int_out}, 32'h0);
    check("rst_cid", {28'b0, cause_id}, 32'h0);

    // Single source 2, latency and ack/EOI
    wr(A_MASK, 32'h4);
    wr(A_CTRL, 32'h1);
    check_reg("ctrl_rd", A_CTRL, 32'h1);
    irq_in = 4'b0100;
    ticks(2);
    check_reg("lat_pend_k1", A_PEND, 32'h0);
    tick();
    check_reg("lat_pend_k2", A_PEND, 32'h4);
    check("lat_int_k2", {31'b0, int_out}, 32'h0);
    tick();
    check("s2_int", {31'b0, int_out}, 32'h1);
    check("s2_cid", {28'b0, cause_id}, 32'h2);
    tick();
    irq_in = '0;
    ack();
    check("s2_ack_int", {31'b0, int_out}, 32'h0);
    check_reg("s2_ack_pend", A_PEND, 32'h0);
    check_reg("s2_ack_cause", A_CAUSE, 32'h80000002);
    wr(A_CAUSE, 32'h0);
    check_reg("s2_eoi_cause", A_CAUSE, 32'h00000002);
    tick();
    check("s2_idle_int", {31'b0, int_out}, 32'h0);

    // Priority between sources 1 and 3
    wr(A_MASK, 32'hF);
    irq_in = 4'b1010;
    ticks(3);
    check_reg("pri_pend", A_PEND, 32'hA);
    tick();
    check("pri_int", {31'b0, int_out}, 32'h1);
    check("pri_cid1", {28'b0, cause_id}, 32'h1);
    irq_in = '0;
    ack();
    check_reg("pri_cause1", A_CAUSE, 32'h80000001);
    check_reg("pri_pend_after", A_PEND, 32'h8);
    wr(A_CAUSE, 32'h0);
    check("pri_eoi_int", {31'b0, int_out}, 32'h0);
    tick();
    check("pri_int3", {31'b0, int_out}, 32'h1);
    check("pri_cid3", {28'b0, cause_id}, 32'h3);
    ack();
    wr(A_CAUSE, 32'h0);

    // Masked pending, unmask, then W1C withdraws the request
    wr(A_MASK, 32'h0);
    irq_in = 4'b0001;
    ticks(3);
    check_reg("msk_pend", A_PEND, 32'h1);
    tick();
    check("msk_int0", {31'b0, int_out}, 32'h0);
    wr(A_MASK, 32'h1);
    check("unmsk_int_same", {31'b0, int_out}, 32'h0);
    tick();
    check("unmsk_int", {31'b0, int_out}, 32'h1);
    wr(A_PEND, 32'h1);
    tick();
    check("w1c_int", {31'b0, int_out}, 32'h0);
    check_reg("w1c_pend", A_PEND, 32'h0);
    check_reg("w1c_cause", A_CAUSE, 32'h0);
    ticks(3);
    check("held_int", {31'b0, int_out}, 32'h0);
    check_reg("held_pend", A_PEND, 32'h0);

    // No nesting while in service
    irq_in = '0;
    ticks(3);
    irq_in = 4'b0001;
    ticks(4);
    check("svc_int", {31'b0, int_out}, 32'h1);
    irq_in = '0;
    ack();
    check_reg("svc_cause", A_CAUSE, 32'h80000000);
    ticks(2);
    irq_in = 4'b0001;
    ticks(3);
    check_reg("svc_pend", A_PEND, 32'h1);
    check("svc_int_blocked", {31'b0, int_out}, 32'h0);
    ticks(2);
    check("svc_int_still", {31'b0, int_out}, 32'h0);
    irq_in = '0;
    wr(A_CAUSE, 32'h0);
    check("svc_eoi_int", {31'b0, int_out}, 32'h0);
    tick();
    check("svc_reassert", {31'b0, int_out}, 32'h1);
    ack();
    wr(A_CAUSE, 32'h0);

    // W1C coincides with the rise of bit 1: set wins
    irq_in = 4'b0010;
    ticks(2);
    wr(A_PEND, 32'h2);
    check_reg("race_pend", A_PEND, 32'h2);
    wr(A_PEND, 32'h2);
    check_reg("w1c_plain", A_PEND, 32'h0);

    // Reset while in REQ
    irq_in = '0;
    ticks(3);
    wr(A_MASK, 32'h8);
    irq_in = 4'b1000;
    ticks(4);
    check("prerst_int", {31'b0, int_out}, 32'h1);
    rst = 1'b1;
    tick();
    check("rstreq_int", {31'b0, int_out}, 32'h0);
    check("rstreq_cid", {28'b0, cause_id}, 32'h0);
    check_reg("rstreq_pend", A_PEND, 32'h0);
    check_reg("rstreq_mask", A_MASK, 32'h0);
    check_reg("rstreq_ctrl", A_CTRL, 32'h0);
    rst = 1'b0;
    irq_in = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller sitting directly upstream of the multi-cycle CPU's single INT input.
- Replaces the raw counter0_out-to-INT wire with synchronized, edge-detected, maskable, prioritized requests from the Counter_x channel outputs and button pulses.
- Registers are reached through MIO_BUS: MIO_BUS address decode drives the write strobe; the read data mux feeds Cpu_data4bus.

Parameters:
- N_SRC, 4, number of request sources (1..16); source 0 has highest priority.
- SYNC_STAGES, 2, synchronizer flops per source (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- irq_in  in  N_SRC  raw level requests (counter0/1/2_out, button pulse); asynchronous to clk
- reg_we  in  1  register write strobe, one cycle, from MIO_BUS decode
- reg_addr  in  2  register select (CPU byte address bits [3:2])
- reg_wdata  in  32  write data (Cpu_data2bus)
- reg_rdata  out  32  combinational read data for the selected register
- int_ack  in  1  one-cycle pulse from the CPU when it enters the interrupt entry state
- int_out  out  1  registered interrupt request to CPU INT
- cause_id  out  4  registered ID of the source being requested/serviced

Behaviour:
- Reset: all pending, mask, ctrl, cause and synchronizer flops are 0. FSM goes to IDLE. int_out=0, cause_id=0.
- Per-source input path:
  - SYNC_STAGES-flop synchronizer, then one extra flop for edge detect.
  - rise = sync_last & ~edge_q.
  - A rise sets PEND[i] on the next edge.
  - Latency: irq_in first sampled high at edge k -> PEND[i]=1 after edge k+2 (SYNC_STAGES=2).
- Register map (reg_addr):
  - 0 PEND: read returns pending bits; write-1-to-clear. A rise on the same cycle as W1C of the same bit leaves it set (set wins).
  - 1 MASK: read/write, bit i=1 enables source i.
  - 2 CTRL: bit0 GIE (global enable), read/write; other bits read 0.
  - 3 CAUSE: read {IS, 27'b0, cause_id} where bit31 IS = in-service. A write of any value is EOI.
  - Unused upper bits read 0.
- Eligibility: elig = PEND & MASK & {N_SRC{GIE}}. The winner is the lowest set index (fixed priority).
- FSM:
  - IDLE: if elig!=0, latch cause_id=winner, int_out<=1, go to REQ (int_out rises the edge after elig becomes nonzero).
  - REQ: int_out held 1. On int_ack: int_out<=0, clear PEND[cause_id], IS<=1, go to SERVICE. If elig for cause_id drops (masked, GIE cleared or W1C) before ack: int_out<=0, return to IDLE; re-arbitration happens next cycle.
  - SERVICE: int_out=0. New requests only accumulate in PEND (no nesting). EOI write: IS<=0, go to IDLE. The next request can assert int_out one cycle later at the earliest.
- Simultaneous events:
  - int_ack and EOI in the same cycle: ack is processed, EOI ignored.
  - EOI outside SERVICE: no effect.
  - int_ack outside REQ: ignored.
- Reset asserted in any state returns to the reset values on the next edge. Pending requests are lost.
- irq_in held high generates exactly one pending event until it falls and rises again.

Decomposition:
- Shared package irq_pkg: register offsets (REG_PEND=0, REG_MASK=1, REG_CTRL=2, REG_CAUSE=3), FSM state encoding (IDLE, REQ, SERVICE), CTRL_GIE bit index, CAUSE_IS bit index 31.
- Sub-module irq_edge_sync (one source): synchronizer plus rising-edge detect, parameter SYNC_STAGES. Instantiated N_SRC times via generate.
- Priority encoder and register file stay in irq_ctrl.

Test Plan:
- Reset, then read all four registers -> each reads 0x00000000; int_out=0.
- MASK=0x4, GIE=1; pulse irq_in[2] high 5 cycles -> PEND=0x4 two edges after first sample; int_out=1 the following edge; cause_id=2. Pulse int_ack -> int_out=0, PEND=0x0, CAUSE reads 0x80000002. Write CAUSE -> CAUSE reads 0x00000002, FSM IDLE.
- MASK=0xF, GIE=1; irq_in[1] and irq_in[3] rise on the same cycle -> cause_id=1. After ack+EOI, int_out reasserts with cause_id=3.
- MASK=0x0; rise irq_in[0] -> PEND=0x1, int_out stays 0. Write MASK=0x1 -> int_out=1 one edge later. Then write PEND=0x1 before ack -> int_out=0, FSM IDLE, PEND=0x0.
- In SERVICE (cause 0), raise irq_in[0] again -> PEND=0x1, int_out stays 0 until EOI, then int_out=1 one cycle after IDLE.
- Write PEND W1C=0x2 on the exact cycle the irq_in[1] edge arrives -> PEND bit1 remains 1. Assert rst while in REQ -> next edge int_out=0, PEND=MASK=CTRL=0.
